// File: rtl/bcd_digit_mul_seq.sv
// Sequential BCD multiplier: NDIG-digit packed BCD operand a times one BCD
// digit b. A single digit-by-digit BCD multiplier is reused once per digit of
// a, least significant digit first, with a BCD carry rippled between steps.
// Optional operand check: define BCD_OPERAND_CHECK_EN to flag non-BCD digits
// on the accepting edge (err=1, result=0, immediate done).
module bcd_digit_mul_seq #(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*NDIG-1:0]     a,
  input  logic [3:0]            b,
  output logic                  busy,
  output logic                  done,
  output logic [4*(NDIG+1)-1:0] result,
  output logic                  err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [4*NDIG-1:0]       a_reg;
  logic [3:0]              b_reg;
  logic [3:0]              carry;
  logic [IW-1:0]           idx;
  logic [4*(NDIG+1)-1:0]   res_reg;
  logic [7:0]              prod;
  logic [4:0]              sum;
  logic [3:0]              dig_out;
  logic [3:0]              carry_nxt;
  logic                    last;
  logic                    accept;

  // Single-digit BCD multiply: two BCD digits in, packed two-digit BCD out.
  function automatic logic [7:0] bcd_mul(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p;
    p = 8'(x) * 8'(y);
    return {4'(p / 8'd10), 4'(p % 8'd10)};
  endfunction

`ifdef BCD_OPERAND_CHECK_EN
  logic err_reg;
  logic bad;

  // True when any digit of the multiplicand or the multiplier exceeds 9.
  function automatic logic has_nonbcd(input logic [4*NDIG-1:0] x, input logic [3:0] y);
    logic r;
    r = (y > 4'd9);
    for (int i = 0; i < NDIG; i++) begin
      if (x[i*4 +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  assign bad = has_nonbcd(a, b);
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = res_reg;
  assign last   = (idx == IW'(NDIG - 1));

  // One digit step: multiply, add incoming carry, split into digit and carry.
  always_comb begin
    prod      = bcd_mul(a_reg[idx*4 +: 4], b_reg);
    sum       = {1'b0, prod[3:0]} + {1'b0, carry};
    dig_out   = sum[3:0];
    carry_nxt = prod[7:4];
    if (sum >= 5'd10) begin
      dig_out   = 4'(sum - 5'd10);
      carry_nxt = prod[7:4] + 4'd1;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef BCD_OPERAND_CHECK_EN
          state_nxt = bad ? DONE : MUL;
`else
          state_nxt = MUL;
`endif
        end
      end
      MUL:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  // Digit index, carry and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      carry   <= '0;
      res_reg <= '0;
    end else if (accept) begin
      idx     <= '0;
      carry   <= '0;
      res_reg <= '0;
    end else if (state == MUL) begin
      res_reg[idx*4 +: 4] <= dig_out;
      carry               <= carry_nxt;
      if (last) begin
        res_reg[NDIG*4 +: 4] <= carry_nxt;
        idx                  <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef BCD_OPERAND_CHECK_EN
  // Error flag: set or cleared by each accepted start, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_reg <= 1'b0;
    else if (accept) err_reg <= bad;
  end
`endif

endmodule

// File: tb/tb_bcd_digit_mul_seq.sv
// Directed plus randomized bench for bcd_digit_mul_seq (NDIG=4). Expected
// products come from decimal arithmetic on the operands.
module tb_bcd_digit_mul_seq;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [3:0]  b = '0;
  logic        busy;
  logic        done;
  logic [19:0] result;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_digit_mul_seq #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [19:0] int2bcd(input int v);
    logic [19:0] r = '0;
    int t = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic has_nonbcd(input logic [15:0] x, input logic [3:0] y);
    logic r = (y > 4'd9);
    for (int i = 0; i < 4; i++) if (x[i*4 +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge. Launches one operation and watches 8 cycles.
  // Observation n is the value the DUT presents at rising edge k+n.
  task automatic run_op(input logic [15:0] av, input logic [3:0] bv,
                        input bit poke, input string tag);
    logic        bad;
    logic [19:0] expv;
    int          lat;
    int          busy_n = 0;
    int          done_n = 0;
    int          done_at = -1;
    logic [19:0] res_at_done = '0;
    logic        err_at_done = 1'b0;
`ifdef BCD_OPERAND_CHECK_EN
    bad = has_nonbcd(av, bv);
`else
    bad = 1'b0;
`endif
    expv = bad ? 20'h0 : int2bcd(bcd2int(av) * int'(bv));
    lat  = bad ? 1 : NDIG + 1;
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 4'($urandom);
    for (int n = 1; n <= 8; n++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++; done_at = n; res_at_done = result; err_at_done = err;
      end
      if (poke && n == 2) begin start = 1'b1; a = 16'h9999; end
      if (poke && n == 3) start = 1'b0;
      if (n == 8) begin
        chk({tag, "_hold"}, 32'(result), 32'(expv));
        chk({tag, "_errhold"}, 32'(err), 32'(bad));
      end
      @(negedge clk);
    end
    chk({tag, "_ndone"}, 32'(done_n), 32'd1);
    chk({tag, "_lat"}, 32'(done_at), 32'(lat));
    chk({tag, "_busy"}, 32'(busy_n), 32'(lat));
    chk({tag, "_res"}, 32'(res_at_done), 32'(expv));
    chk({tag, "_err"}, 32'(err_at_done), 32'(bad));
  endtask

  initial begin
    logic [15:0] ra;
    int          done_n;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // First start together with reset release
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h9999, 4'h9, 1'b0, "max");
    run_op(16'h1234, 4'h5, 1'b0, "d1234x5");
    run_op(16'h0000, 4'h7, 1'b0, "zero_a");
    run_op(16'h8765, 4'h0, 1'b0, "zero_b");
    run_op(16'h0001, 4'h2, 1'b1, "ignore_start");

    // Randomized operands
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 4; i++) ra[i*4 +: 4] = 4'($urandom_range(0, 9));
      run_op(ra, 4'($urandom_range(0, 9)), 1'b0, "rand");
    end

    // Start held high launches back-to-back operations
    a = 16'h0002; b = 4'h3; start = 1'b1;
    done_n = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        chk("held_res", 32'(result), 32'h6);
      end
    end
    start = 1'b0;
    chk("held_ndone", 32'(done_n), 32'd2);
    repeat (8) @(negedge clk);

    // Reset during MUL aborts the operation
    a = 16'h4321; b = 4'h8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("abort_nodone", 32'(done_n), 32'd0);
    run_op(16'h4321, 4'h8, 1'b0, "after_abort");

`ifdef BCD_OPERAND_CHECK_EN
    run_op(16'h12A4, 4'h3, 1'b0, "nonbcd_a");
    run_op(16'h0011, 4'h3, 1'b0, "clear_err");
    run_op(16'h0011, 4'hC, 1'b0, "nonbcd_b");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
